serv_ibus_resp: RTL and testbench
=================================

SERV_IBUS_RESP -- requirements
Module: serv_ibus_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction words held; power of two, 4..4096.
REQ-002 SHALL have parameter WAIT, default 1: wait states between request sample and ack; 0..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_wb_cyc, input, 1: instruction fetch request from core.
REQ-006 SHALL have port i_wb_adr, input, 30: word address, bits [31:2].
REQ-007 SHALL have port o_wb_rdt, output, 32: instruction word, valid only while o_wb_ack=1.
REQ-008 SHALL have port o_wb_ack, output, 1: one-cycle fetch completion strobe.
REQ-009 SHALL have port i_ld_en, input, 1: program-load write strobe.
REQ-010 SHALL have port i_ld_adr, input, log2(DEPTH): program-load word index.
REQ-011 SHALL have port i_ld_dat, input, 32: program-load word.
REQ-012 SHALL have port o_busy, output, 1: high in any state other than IDLE.

Function
REQ-013 SHALL be the responder end of the instruction bus: serves fetches whose returned word the core's decoder registers on ack.
REQ-014 SHALL implement FSM IDLE, WAIT, ACK.
REQ-015 IDLE with i_wb_cyc=1 SHALL latch i_wb_adr, load wait counter with WAIT, go to WAIT (WAIT>0) or ACK (WAIT=0).
REQ-016 WAIT SHALL decrement counter each cycle; counter=1 with i_wb_cyc=1 SHALL go to ACK.
REQ-017 i_wb_cyc=0 in WAIT SHALL abort to IDLE next cycle, no ack issued.
REQ-018 o_wb_rdt SHALL be read from memory at the latched address on the cycle entering ACK and registered; o_wb_ack=1 for exactly one cycle in ACK.
REQ-019 ACK SHALL always return to IDLE; a new request is sampled no earlier than the cycle after ack, giving request-to-ack latency WAIT+1 cycles.
REQ-020 o_wb_rdt SHALL be 0 whenever o_wb_ack=0.
REQ-021 i_ld_en=1 SHALL write i_ld_dat to word i_ld_adr that cycle, in any state.
REQ-022 Load to the same word on the cycle rdt is registered SHALL return the old word; the new word is visible from the next cycle.
REQ-023 Address index SHALL be i_wb_adr[log2(DEPTH)-1:0]; upper bits per REQ-029/030.

Reset
REQ-024 i_rst_n=0 SHALL immediately force state IDLE, counter 0, o_wb_ack=0, o_wb_rdt=0, o_busy=0 (and o_wb_err=0 when present).
REQ-025 Reset mid-WAIT or mid-ACK SHALL drop the transaction; no ack after reset release.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 First request SHALL be sampled on the first rising edge after i_rst_n deasserts.

Configuration
REQ-028 Macro SERV_IBUS_ERR_EN SHALL select out-of-range handling.
REQ-029 Without SERV_IBUS_ERR_EN: address bits above index SHALL be ignored (aliasing modulo DEPTH); no o_wb_err port.
REQ-030 With SERV_IBUS_ERR_EN: port o_wb_err, output, 1 SHALL exist; a latched address >= DEPTH SHALL produce, at ack time, o_wb_err=1, o_wb_ack=0, o_wb_rdt=0x00000013 (NOP) for one cycle, then IDLE.

Verification
REQ-031 WAIT=1: load word 5 = 0x00500093, reset, cyc=1 adr=5 -> ack exactly 2 cycles after request sample, rdt=0x00500093, ack 1 cycle.
REQ-032 WAIT=3: cyc=1 adr=2, drop cyc after 1 cycle -> no ack, o_busy low within 2 cycles; next request acks normally.
REQ-033 WAIT=0, word 7 = 0x11111111: load 0x22222222 to word 7 on rdt-register cycle -> rdt=0x11111111; refetch -> 0x22222222.
REQ-034 DEPTH=256, adr=0x105, no macro -> rdt equals word 5; with SERV_IBUS_ERR_EN -> o_wb_err=1, o_wb_ack=0, rdt=0x00000013.
REQ-035 Assert i_rst_n=0 in ACK cycle -> o_wb_ack and o_wb_rdt 0 same cycle (async); memory words unchanged after release.
REQ-036 Back-to-back: cyc held high over 4 fetches WAIT=1 -> acks every 3 cycles, never two consecutive ack cycles.

Source files
------------

// File: rtl/serv_ibus_resp.sv
// Instruction-bus responder: serves core fetches from a loadable word memory after WAIT wait states.
// Optional macro SERV_IBUS_ERR_EN: out-of-range fetches raise o_wb_err with a NOP instead of aliasing.
module serv_ibus_resp #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 1
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_wb_cyc,
  input  logic [29:0]              i_wb_adr,
  output logic [31:0]              o_wb_rdt,
  output logic                     o_wb_ack,
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_adr,
  input  logic [31:0]              i_ld_dat,
`ifdef SERV_IBUS_ERR_EN
  output logic                     o_wb_err,
`endif
  output logic                     o_busy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [AW-1:0]  idx_q;
  logic           ack_q;
  logic           busy_q;
  logic [31:0]    rdt_q;
  logic [31:0]    mem_q [DEPTH];

  logic [AW-1:0]  idx_d;
  logic [31:0]    word_d;
  logic           go_ack_s;

`ifdef SERV_IBUS_ERR_EN
  logic           oob_q;
  logic           oob_d;
  logic           err_q;
`else
  logic           unused_adr_s;
  assign unused_adr_s = ^i_wb_adr[29:AW];
`endif

  // Read index: the live address when responding straight from IDLE, else the latched one
  always_comb begin
    idx_d = idx_q;
    if (state_q == ST_IDLE) begin
      idx_d = i_wb_adr[AW-1:0];
    end else begin
      idx_d = idx_q;
    end
    word_d = mem_q[idx_d];
`ifdef SERV_IBUS_ERR_EN
    if (state_q == ST_IDLE) begin
      oob_d = |i_wb_adr[29:AW];
    end else begin
      oob_d = oob_q;
    end
`endif
  end

  // Decide whether this edge enters ACK
  always_comb begin
    go_ack_s = 1'b0;
    case (state_q)
      ST_IDLE: go_ack_s = i_wb_cyc && (WAIT == 0);
      ST_WAIT: go_ack_s = i_wb_cyc && (cnt_q == 4'd1);
      default: go_ack_s = 1'b0;
    endcase
  end

  // Fetch FSM with registered ack/rdt/busy
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      rdt_q   <= 32'd0;
      busy_q  <= 1'b0;
`ifdef SERV_IBUS_ERR_EN
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_wb_cyc) begin
            idx_q  <= i_wb_adr[AW-1:0];
            cnt_q  <= WAIT_LD;
            busy_q <= 1'b1;
`ifdef SERV_IBUS_ERR_EN
            oob_q  <= |i_wb_adr[29:AW];
`endif
            state_q <= (WAIT == 0) ? ST_ACK : ST_WAIT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!i_wb_cyc) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            busy_q  <= 1'b1;
            state_q <= (cnt_q == 4'd1) ? ST_ACK : ST_WAIT;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // The old word is captured here even if a load hits the same index this edge
      if (go_ack_s) begin
`ifdef SERV_IBUS_ERR_EN
        if (oob_d) begin
          ack_q <= 1'b0;
          err_q <= 1'b1;
          rdt_q <= NOP;
        end else begin
          ack_q <= 1'b1;
          err_q <= 1'b0;
          rdt_q <= word_d;
        end
`else
        ack_q <= 1'b1;
        rdt_q <= word_d;
`endif
      end else begin
        ack_q <= 1'b0;
        rdt_q <= 32'd0;
`ifdef SERV_IBUS_ERR_EN
        err_q <= 1'b0;
`endif
      end
    end
  end

  // Program-load port; contents survive reset
  always_ff @(posedge clk) begin
    if (i_ld_en) begin
      mem_q[i_ld_adr] <= i_ld_dat;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_busy   = busy_q;
`ifdef SERV_IBUS_ERR_EN
  assign o_wb_err = err_q;
`endif

endmodule

// File: tb/tb_serv_ibus_resp.sv
// Directed bench for serv_ibus_resp: three instances (WAIT=1, 3, 0) share all inputs.
module tb_serv_ibus_resp;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic [29:0] adr;
  logic        ld_en;
  logic [7:0]  ld_adr;
  logic [31:0] ld_dat;

  logic [31:0] rdt1, rdt3, rdt0;
  logic        ack1, ack3, ack0;
  logic        busy1, busy3, busy0;
`ifdef SERV_IBUS_ERR_EN
  logic        err1, err3, err0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serv_ibus_resp #(.DEPTH(256), .WAIT(1)) u_w1 (
    .clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_adr(adr),
    .o_wb_rdt(rdt1), .o_wb_ack(ack1),
    .i_ld_en(ld_en), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat),
`ifdef SERV_IBUS_ERR_EN
    .o_wb_err(err1),
`endif
    .o_busy(busy1)
  );

  serv_ibus_resp #(.DEPTH(256), .WAIT(3)) u_w3 (
    .clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_adr(adr),
    .o_wb_rdt(rdt3), .o_wb_ack(ack3),
    .i_ld_en(ld_en), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat),
`ifdef SERV_IBUS_ERR_EN
    .o_wb_err(err3),
`endif
    .o_busy(busy3)
  );

  serv_ibus_resp #(.DEPTH(256), .WAIT(0)) u_w0 (
    .clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_adr(adr),
    .o_wb_rdt(rdt0), .o_wb_ack(ack0),
    .i_ld_en(ld_en), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat),
`ifdef SERV_IBUS_ERR_EN
    .o_wb_err(err0),
`endif
    .o_busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int   acks;
    logic prev_ack;
    logic exp_ack;

    rst_n  = 1'b0;
    cyc    = 1'b0;
    adr    = 30'd0;
    ld_en  = 1'b0;
    ld_adr = 8'd0;
    ld_dat = 32'd0;
    tick();
    tick();

    chk1 ("rst_ack",  ack1,  1'b0);
    chk32("rst_rdt",  rdt1,  32'd0);
    chk1 ("rst_busy", busy1, 1'b0);
`ifdef SERV_IBUS_ERR_EN
    chk1 ("rst_err",  err1,  1'b0);
`endif

    // program load while held in reset
    ld_en = 1'b1; ld_adr = 8'd5; ld_dat = 32'h0050_0093; tick();
    ld_adr = 8'd7; ld_dat = 32'h1111_1111; tick();
    ld_adr = 8'd2; ld_dat = 32'hDEAD_0002; tick();
    ld_en = 1'b0;
    chk1 ("rst_busy3", busy3, 1'b0);

    // first request sampled on the first edge after release
    rst_n = 1'b1; cyc = 1'b1; adr = 30'd5;
    tick();
    chk1 ("w1_wait_ack",  ack1,  1'b0);
    chk1 ("w1_wait_busy", busy1, 1'b1);
    chk1 ("w0_lat_ack",   ack0,  1'b1);
    chk32("w0_lat_rdt",   rdt0,  32'h0050_0093);
    tick();
    chk1 ("w1_ack",     ack1, 1'b1);
    chk32("w1_rdt",     rdt1, 32'h0050_0093);
    chk1 ("w0_ack_one", ack0, 1'b0);
    cyc = 1'b0;
    tick();
    chk1 ("w1_ack_one", ack1,  1'b0);
    chk32("w1_rdt_off", rdt1,  32'd0);
    chk1 ("w1_idle",    busy1, 1'b0);
    tick(); tick(); tick();

    // abort during WAIT on the WAIT=3 instance
    cyc = 1'b1; adr = 30'd2;
    tick();
    chk1("w3_busy", busy3, 1'b1);
    cyc = 1'b0;
    tick();
    chk1("w3_abort_busy", busy3, 1'b0);
    chk1("w3_abort_ack",  ack3,  1'b0);
    tick();
    chk1("w3_abort_ack2", ack3,  1'b0);

    cyc = 1'b1; adr = 30'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("w3_wait_ack", ack3, 1'b0);
    end
    tick();
    chk1 ("w3_ack", ack3, 1'b1);
    chk32("w3_rdt", rdt3, 32'hDEAD_0002);
    cyc = 1'b0;
    tick();
    chk1 ("w3_ack_one", ack3,  1'b0);
    chk1 ("w3_idle",    busy3, 1'b0);
    tick(); tick(); tick();

    // load collides with the rdt-register edge on the WAIT=0 instance
    cyc = 1'b1; adr = 30'd7; ld_en = 1'b1; ld_adr = 8'd7; ld_dat = 32'h2222_2222;
    tick();
    chk1 ("w0_coll_ack", ack0, 1'b1);
    chk32("w0_coll_rdt", rdt0, 32'h1111_1111);
    cyc = 1'b0; ld_en = 1'b0;
    tick();
    chk1 ("w0_gap_ack", ack0, 1'b0);
    chk32("w0_gap_rdt", rdt0, 32'd0);
    cyc = 1'b1; adr = 30'd7;
    tick();
    chk1 ("w0_refetch_ack", ack0, 1'b1);
    chk32("w0_refetch_rdt", rdt0, 32'h2222_2222);
    cyc = 1'b0;
    tick(); tick(); tick();

    // address above DEPTH
    cyc = 1'b1; adr = 30'h105;
    tick();
`ifdef SERV_IBUS_ERR_EN
    chk1 ("w0_oob_err", err0, 1'b1);
    chk1 ("w0_oob_ack", ack0, 1'b0);
    chk32("w0_oob_rdt", rdt0, 32'h0000_0013);
`else
    chk1 ("w0_alias_ack", ack0, 1'b1);
    chk32("w0_alias_rdt", rdt0, 32'h0050_0093);
`endif
    tick();
`ifdef SERV_IBUS_ERR_EN
    chk1 ("w1_oob_err", err1, 1'b1);
    chk1 ("w1_oob_ack", ack1, 1'b0);
    chk32("w1_oob_rdt", rdt1, 32'h0000_0013);
`else
    chk1 ("w1_alias_ack", ack1, 1'b1);
    chk32("w1_alias_rdt", rdt1, 32'h0050_0093);
`endif
    cyc = 1'b0;
    tick();
    chk1 ("w1_oob_after", ack1,  1'b0);
    chk1 ("w1_oob_idle",  busy1, 1'b0);
`ifdef SERV_IBUS_ERR_EN
    chk1 ("w1_err_one",   err1,  1'b0);
`endif
    tick(); tick();

    // asynchronous reset in the middle of ACK (WAIT=3 instance is mid-WAIT)
    cyc = 1'b1; adr = 30'd5;
    tick(); tick();
    chk1("w1_pre_rst_ack", ack1, 1'b1);
    cyc = 1'b0; rst_n = 1'b0;
    #1;
    chk1 ("w1_async_ack",  ack1,  1'b0);
    chk32("w1_async_rdt",  rdt1,  32'd0);
    chk1 ("w1_async_busy", busy1, 1'b0);
    chk1 ("w3_async_busy", busy3, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("w1_no_ack_post_rst", ack1, 1'b0);
      chk1("w3_no_ack_post_rst", ack3, 1'b0);
    end
    cyc = 1'b1; adr = 30'd5;
    tick(); tick();
    chk1 ("w1_mem5_ack", ack1, 1'b1);
    chk32("w1_mem5_kept", rdt1, 32'h0050_0093);
    cyc = 1'b0;
    tick();
    cyc = 1'b1; adr = 30'd7;
    tick();
    chk1 ("w0_mem7_ack", ack0, 1'b1);
    chk32("w0_mem7_kept", rdt0, 32'h2222_2222);
    cyc = 1'b0;
    tick(); tick(); tick(); tick();

    // back-to-back fetches with cyc held high
    acks = 0;
    prev_ack = 1'b0;
    cyc = 1'b1; adr = 30'd5;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_ack = ((k % 3) == 2);
      chk1 ("b2b_ack", ack1, exp_ack);
      chk32("b2b_rdt", rdt1, exp_ack ? 32'h0050_0093 : 32'd0);
      chk1 ("b2b_no_consec", ack1 & prev_ack, 1'b0);
      if (ack1) acks++;
      prev_ack = ack1;
    end
    cyc = 1'b0;
    chk32("b2b_count", acks, 32'd4);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
